// File: rtl/load_ext_pkg.sv
// Shared types for the load-data formatter: access-size encodings and the
// result entry that travels through the output FIFO.
package load_ext_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef struct packed {
      logic [31:0] data;
      logic        misalign;
   } entry_t;

endpackage

// File: rtl/load_ext_fmt.sv
// Combinational lane select and sign/zero extension of a raw read word,
// with misalignment detection for half/word accesses and the reserved size.
module load_ext_fmt
   import load_ext_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] data,
   input  logic [1:0]        addr,
   input  logic [1:0]        size,
   input  logic              sign,
   output entry_t            entry
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Lane offsets come straight from the byte address bits.
   assign byte_lane = data[{addr, 3'b000} +: 8];
   assign half_lane = data[{addr[1], 4'b0000} +: 16];

   always_comb begin
      entry = '0;
      case (size)
         SZ_BYTE: entry.data = {{24{sign & byte_lane[7]}}, byte_lane};
         SZ_HALF: begin
            if (addr[0]) entry.misalign = 1'b1;
            else         entry.data = {{16{sign & half_lane[15]}}, half_lane};
         end
         SZ_WORD: begin
            if (addr != 2'b00) entry.misalign = 1'b1;
            else               entry.data = data[31:0];
         end
         default: entry.misalign = 1'b1;
      endcase
   end

endmodule

// File: rtl/load_ext_pipe.sv
// Load-data formatter with a small result FIFO, valid/ready handshakes on both
// sides and a saturating counter of misaligned requests.
module load_ext_pipe
   import load_ext_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int BUF_DEPTH = 2,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [1:0]        in_addr,
   input  logic [1:0]        in_size,
   input  logic              in_sign,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_data,
   output logic              out_misalign,
   output logic [CNT_W-1:0]  misalign_cnt
);

   localparam int         PW    = $clog2(BUF_DEPTH);
   localparam logic [PW:0] DEPTH = (PW + 1)'(BUF_DEPTH);

   entry_t          fmt_entry;
   entry_t          mem_reg [BUF_DEPTH];
   logic [PW-1:0]   wr_ptr_reg;
   logic [PW-1:0]   rd_ptr_reg;
   logic [PW:0]     count_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic            full;
   logic            push;
   logic            pop;

   load_ext_fmt #(.DATA_W(DATA_W)) u_fmt (
      .data  (in_data),
      .addr  (in_addr),
      .size  (in_size),
      .sign  (in_sign),
      .entry (fmt_entry)
   );

   assign full      = (count_reg == DEPTH);
   assign in_ready  = !full && !rst && !flush;
   assign out_valid = (count_reg != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   assign out_data     = mem_reg[rd_ptr_reg].data;
   assign out_misalign = mem_reg[rd_ptr_reg].misalign;
   assign misalign_cnt = cnt_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         cnt_reg    <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) mem_reg[i] <= '0;
      end else if (flush) begin
         // Counter survives a flush; any same-cycle push is already blocked by in_ready.
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            mem_reg[wr_ptr_reg] <= fmt_entry;
            wr_ptr_reg          <= wr_ptr_reg + PW'(1);
            if (fmt_entry.misalign && (cnt_reg != '1))
               cnt_reg <= cnt_reg + CNT_W'(1);
         end
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + (PW + 1)'(1);
            2'b01:   count_reg <= count_reg - (PW + 1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: tb/tb_load_ext_pipe.sv
// Scoreboard bench for load_ext_pipe: expected entries are queued at acceptance
// and compared in order as results are released.
module tb_load_ext_pipe;
   import load_ext_pkg::*;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, in_sign;
   logic [31:0] in_data;
   logic [1:0]  in_addr, in_size;
   logic        out_valid, out_ready, out_misalign;
   logic [31:0] out_data;
   logic [3:0]  misalign_cnt;

   logic [31:0] exp_data;
   logic        exp_mis;
   logic [32:0] sb [$];
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   load_ext_pipe #(.DATA_W(32), .BUF_DEPTH(2), .CNT_W(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_addr      (in_addr),
      .in_size      (in_size),
      .in_sign      (in_sign),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_misalign (out_misalign),
      .misalign_cnt (misalign_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Independent reference: shift-and-mask extraction.
   function automatic logic [32:0] model(input logic [31:0] d, input logic [1:0] a,
                                         input logic [1:0] s, input logic sg);
      logic [31:0] v;
      v = 32'h0;
      if (s == 2'b00) begin
         v = (d >> (a * 8)) & 32'h0000_00FF;
         if (sg && v[7]) v = v | 32'hFFFF_FF00;
         return {v, 1'b0};
      end
      if (s == 2'b01 && (a == 2'd0 || a == 2'd2)) begin
         v = (d >> (a * 8)) & 32'h0000_FFFF;
         if (sg && v[15]) v = v | 32'hFFFF_0000;
         return {v, 1'b0};
      end
      if (s == 2'b10 && a == 2'd0) return {d, 1'b0};
      return {32'h0, 1'b1};
   endfunction

   always @(negedge clk) begin
      logic [32:0] e;
      if (rst || flush) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", {31'h0, out_valid}, 32'h0);
            end else begin
               e = sb.pop_front();
               $display("pop data=%h mis=%0d", out_data, out_misalign);
               chk("pop_data", out_data, e[32:1]);
               chk("pop_mis", {31'h0, out_misalign}, {31'h0, e[0]});
            end
         end
         if (in_valid && in_ready) sb.push_back({exp_data, exp_mis});
      end
   end

   task automatic drive(input logic [31:0] d, input logic [1:0] a, input logic [1:0] s,
                        input logic sg, input logic [31:0] ed, input logic em);
      in_data  = d;
      in_addr  = a;
      in_size  = s;
      in_sign  = sg;
      exp_data = ed;
      exp_mis  = em;
      in_valid = 1'b1;
   endtask

   task automatic send(input logic [31:0] d, input logic [1:0] a, input logic [1:0] s,
                       input logic sg, input logic [31:0] ed, input logic em);
      logic ok;
      drive(d, a, s, sg, ed, em);
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         if (ok) begin
            in_valid = 1'b0;
            return;
         end
      end
      chk("send_timeout", {31'h0, in_ready}, 32'h1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 100; n++) begin
         if (sb.size() == 0 && !out_valid) return;
         @(posedge clk);
         #1;
      end
      chk("drain_timeout", sb.size(), 32'h0);
   endtask

   initial begin
      logic [31:0] lane_s [4];
      logic [31:0] lane_u [4];
      logic [32:0] m;
      logic [31:0] d;
      logic [1:0]  a, s;
      logic [3:0]  c;
      int          sat;

      lane_s = '{32'h0000007F, 32'hFFFFFFF2, 32'hFFFFFF81, 32'hFFFFFF80};
      lane_u = '{32'h0000007F, 32'h000000F2, 32'h00000081, 32'h00000080};
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_data = '0; in_addr = '0; in_size = '0; in_sign = 1'b0;
      exp_data = '0; exp_mis = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
      chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_out_mis", {31'h0, out_misalign}, 32'h0);
      chk("rst_cnt", {28'h0, misalign_cnt}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Byte lanes, signed then unsigned; then halfwords.
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++)
         send(32'h8081F27F, 2'(i), SZ_BYTE, 1'b1, lane_s[i], 1'b0);
      for (int i = 0; i < 4; i++)
         send(32'h8081F27F, 2'(i), SZ_BYTE, 1'b0, lane_u[i], 1'b0);
      send(32'h7FFF8000, 2'd0, SZ_HALF, 1'b1, 32'hFFFF8000, 1'b0);
      send(32'h7FFF8000, 2'd2, SZ_HALF, 1'b1, 32'h00007FFF, 1'b0);
      send(32'h7FFF8000, 2'd1, SZ_HALF, 1'b1, 32'h00000000, 1'b1);
      chk("half_cnt", {28'h0, misalign_cnt}, 32'h1);
      drain();

      // Backpressure: two accepts fill the FIFO, third waits for the first pop.
      out_ready = 1'b0;
      drive(32'hA0000001, 2'd0, SZ_WORD, 1'b0, 32'hA0000001, 1'b0);
      @(negedge clk); chk("bp_rdy0", {31'h0, in_ready}, 32'h1);
      @(posedge clk); #1;
      drive(32'hA0000002, 2'd0, SZ_WORD, 1'b1, 32'hA0000002, 1'b0);
      @(negedge clk); chk("bp_rdy1", {31'h0, in_ready}, 32'h1);
      @(posedge clk); #1;
      drive(32'hA0000003, 2'd0, SZ_WORD, 1'b0, 32'hA0000003, 1'b0);
      @(negedge clk); chk("bp_full", {31'h0, in_ready}, 32'h0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk); chk("bp_full_pop", {31'h0, in_ready}, 32'h0);
      @(posedge clk); #1;
      @(negedge clk); chk("bp_third", {31'h0, in_ready}, 32'h1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      drain();

      // Throughput: one accept and one release per cycle.
      for (int i = 0; i < 8; i++) begin
         d = $urandom; a = 2'($urandom_range(0, 3)); s = 2'($urandom_range(0, 3));
         m = model(d, a, s, i[0]);
         drive(d, a, s, i[0], m[32:1], m[0]);
         @(negedge clk);
         chk("tp_rdy", {31'h0, in_ready}, 32'h1);
         chk("tp_valid", {31'h0, out_valid}, (i > 0) ? 32'h1 : 32'h0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(negedge clk); chk("tp_last", {31'h0, out_valid}, 32'h1);
      @(posedge clk); #1;
      @(negedge clk); chk("tp_idle", {31'h0, out_valid}, 32'h0);
      @(posedge clk); #1;
      drain();

      // Flush with two queued entries.
      out_ready = 1'b0;
      c = misalign_cnt;
      send(32'h11223344, 2'd0, SZ_WORD, 1'b0, 32'h11223344, 1'b0);
      send(32'h11223344, 2'd3, SZ_HALF, 1'b0, 32'h0, 1'b1);
      chk("fl_cnt_pre", {28'h0, misalign_cnt}, {28'h0, c + 4'd1});
      drive(32'h0, 2'd1, SZ_RSVD, 1'b0, 32'h0, 1'b1);
      flush = 1'b1;
      @(negedge clk);
      chk("fl_rdy", {31'h0, in_ready}, 32'h0);
      chk("fl_valid_pre", {31'h0, out_valid}, 32'h1);
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("fl_valid", {31'h0, out_valid}, 32'h0);
      chk("fl_cnt", {28'h0, misalign_cnt}, {28'h0, c + 4'd1});
      chk("fl_rdy_after", {31'h0, in_ready}, 32'h1);

      // Reset mid-stream clears the counter.
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk); chk("rst2_rdy", {31'h0, in_ready}, 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst2_cnt", {28'h0, misalign_cnt}, 32'h0);
      chk("rst2_valid", {31'h0, out_valid}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Counter saturation at 15 with a 4-bit counter.
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         send(32'h12345678, 2'd1, SZ_WORD, 1'b0, 32'h0, 1'b1);
         sat = (i + 1 > 15) ? 15 : i + 1;
         chk("sat_cnt", {28'h0, misalign_cnt}, sat);
      end
      drain();
      chk("sb_left", sb.size(), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/load_ext_pipe.md
Name: load_ext_pipe

Overview:
Parametrised load-data formatter for the memory stage of the CPU. It selects a byte, halfword or word lane from a raw memory read word using the low address bits, then sign- or zero-extends the result to 32 bits. Results are buffered in a small FIFO with valid/ready handshakes on both sides. The block detects misaligned accesses, flags them, and counts them. It sits between the data-memory read port and the writeback mux.

Parameters:
DATA_W, 32, raw read-data width; only 32 is supported. Lane selection uses address bits [1:0].
BUF_DEPTH, 2, result FIFO depth; must be a power of 2 and >= 2.
CNT_W, 16, width of the saturating misalignment counter.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
flush  input  1  synchronous FIFO clear; the counter is preserved
in_valid  input  1  request valid
in_ready  output  1  block can accept a request
in_data  input  DATA_W  raw memory word
in_addr  input  2  byte offset, address[1:0]
in_size  input  2  00 byte, 01 half, 10 word, 11 reserved
in_sign  input  1  1 = sign-extend, 0 = zero-extend
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
out_data  output  32  extended load result
out_misalign  output  1  result is a misalignment exception
misalign_cnt  output  CNT_W  saturating count of misaligned requests

Behaviour:
- Clock and reset: one clock (clk); synchronous active-high reset (rst).
- Reset values: out_valid=0, out_data=0, out_misalign=0, misalign_cnt=0, FIFO empty. in_ready=0 while rst=1.
- Accept and release:
  - A request is accepted when in_valid & in_ready.
  - A result is released when out_valid & out_ready.
  - in_ready = !full & !rst & !flush. It is combinational from the occupancy count.
- Latency and ordering:
  - Into an empty FIFO, out_valid rises the cycle after acceptance; there is no combinational bypass.
  - Results leave strictly in order.
  - out_data and out_misalign are driven from registered FIFO head storage.
- Push and pop:
  - Simultaneous push and pop when non-empty and non-full: occupancy unchanged.
  - When full, in_ready=0, so no push occurs even if a pop happens in that cycle.
- Byte lane (in_size=00): byte = in_data[8*addr+7 : 8*addr]. Extended with in_sign & byte[7].
- Half lane (in_size=01): requires addr[0]=0. half = in_data[16*addr[1]+15 : 16*addr[1]]. Extended with in_sign & half[15].
- Word (in_size=10): requires addr=00. in_data is passed through; in_sign is ignored.
- Misaligned or reserved size:
  - Covers half with addr[0]=1, word with addr!=00, and in_size=11.
  - The entry is stored with out_data=0 and out_misalign=1.
  - misalign_cnt increments on acceptance and saturates at all-ones.
- flush:
  - Empties the FIFO on the next edge and drops any same-cycle push.
  - out_valid=0 the following cycle.
  - A same-cycle accepted misaligned request is not counted.
- rst asserted mid-stream discards all entries and clears the counter.
- No assumption is made about out_ready stability; out_data must hold while out_valid & !out_ready.

Decomposition:
- Package load_ext_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD;
  - the result-entry struct {data[31:0], misalign}.
- Sub-module load_ext_fmt: the combinational lane select, extension and misalignment check, a parametrised successor of the existing extender.
- The FIFO, handshakes and counter live in load_ext_pipe.

Test Plan:
- Lane extraction: in_data=32'h8081F27F, size=00, sign=1, addr=0..3 -> out_data 0000007F, FFFFFFF2, FFFFFF81, FFFFFF80. With sign=0 -> 0000007F, 000000F2, 00000081, 00000080.
- Halfword: in_data=32'h7FFF8000, size=01, sign=1, addr=0 -> FFFF8000. addr=2 -> 00007FFF. addr=1 -> out_data 0, out_misalign=1, misalign_cnt=1.
- Backpressure: out_ready=0, push 3 words with BUF_DEPTH=2 -> in_ready=0 after 2 accepts. Raise out_ready -> results emerge in order, third accepted the cycle after the first pop.
- Throughput: out_ready=1, in_valid=1 continuously for 8 cycles -> 8 results, first out_valid 1 cycle after first accept, one result per cycle thereafter.
- Counter saturation with CNT_W=4: 20 word requests at addr=01 -> misalign_cnt stops at 15.
- Flush and reset: 2 entries queued, assert flush -> out_valid=0 next cycle, misalign_cnt unchanged. Then assert rst -> misalign_cnt=0 and in_ready=0 during reset.
